regfile_wb: RTL



---
 rtl/regfile_wb.sv | 97 +++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// Write-back stage: one-entry pending write register feeding a 32x32 architectural
// register file. The two combinational read ports bypass from the pending entry.
// Latency: a write is visible via bypass 1 cycle after it is presented and in the array after 2.
// Backpressure: stall holds the pending entry and drops the inputs; flush kills the input.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   WE3, A3, WD      write enable, destination register and data leaving the memory stage
//   stall, flush     hold / kill control for the pending write-back entry
//   A1/RD1, A2/RD2   combinational read ports (register 0 reads as zero)
//   WBPend           registered flag: a valid write is waiting to commit
module regfile_wb #(
  parameter int AWIDTH  = 32,
  parameter int RDEPTH  = 32,
  parameter int RAWIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WE3,
  input  logic [RAWIDTH-1:0] A3,
  input  logic [AWIDTH-1:0]  WD,
  input  logic               stall,
  input  logic               flush,
  input  logic [RAWIDTH-1:0] A1,
  input  logic [RAWIDTH-1:0] A2,
  output logic [AWIDTH-1:0]  RD1,
  output logic [AWIDTH-1:0]  RD2,
  output logic               WBPend
);

  logic [AWIDTH-1:0]  regs_q [RDEPTH];
  logic               pv_q, pv_d;
  logic [RAWIDTH-1:0] pa_q, pa_d;
  logic [AWIDTH-1:0]  pd_q, pd_d;
  logic               commit;

  // Writes to register 0 are filtered at capture, but the address check is kept
  // at commit too so the zero register can never be disturbed.
  assign commit = pv_q && (pa_q != '0);

  // Capture priority: flush beats stall; a stalled entry is simply held, and
  // re-committing it on the next edge rewrites the same value.
  always_comb begin
    pv_d = pv_q;
    pa_d = pa_q;
    pd_d = pd_q;
    if (flush) begin
      pv_d = 1'b0;
    end else if (!stall) begin
      pv_d = WE3 && (A3 != '0);
      pa_d = A3;
      pd_d = WD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // A pending write is dropped here, never committed.
      for (int i = 0; i < RDEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pv_q <= 1'b0;
      pa_q <= '0;
      pd_q <= '0;
    end else begin
      if (commit) begin
        regs_q[pa_q] <= pd_q;
      end
      pv_q <= pv_d;
      pa_q <= pa_d;
      pd_q <= pd_d;
    end
  end

  // Read: zero register first, then bypass from the pending entry, then the array.
  // There is deliberately no bypass from the WD/A3 inputs of the same cycle.
  always_comb begin
    RD1 = regs_q[A1];
    if (A1 == '0) begin
      RD1 = '0;
    end else if (pv_q && (pa_q == A1)) begin
      RD1 = pd_q;
    end
  end

  always_comb begin
    RD2 = regs_q[A2];
    if (A2 == '0) begin
      RD2 = '0;
    end else if (pv_q && (pa_q == A2)) begin
      RD2 = pd_q;
    end
  end

  assign WBPend = pv_q;

endmodule
